// File: rtl/adder16_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : adder16_accum_if
// Description : Operand-in / result-out bundle for the adder16 accumulator.
//               master = upstream producer and result consumer,
//               slave  = the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder16_accum_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   // operand beat stream
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;

   // per-packet result
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_sign;
   logic             out_zero;
   logic             out_carry;
   logic             out_parity;
   logic             out_overflow;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_sign, out_zero,
             out_carry, out_parity, out_overflow, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_sign, out_zero,
             out_carry, out_parity, out_overflow, out_count
   );
endinterface
`default_nettype wire

// File: rtl/adder16_accum.sv
`default_nettype none
// ============================================================================
// Module      : adder16_accum
// Description : Streaming packet accumulator. Sums in_last-delimited operand
//               packets and presents one result per packet with Sign, Zero,
//               Carry (sticky), Parity and Overflow (sticky) flags plus a
//               saturating beat count.
//               Optional macro ADDER16_ACCUM_SAT_EN: clamp the accumulator
//               to the signed extremes on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module adder16_accum #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  wire               clk,
   input  wire               rst_n,
   adder16_accum_if.slave    bus
);
   localparam int MSB = WIDTH - 1;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ADDER16_ACCUM_SAT_EN
   localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic             r_ovf;
   logic [CNT_W-1:0] r_count;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_beat;
   logic [WIDTH:0]   w_sum_ext;
   logic             w_cout;
   logic             w_add_ovf;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] w_count_inc;

   assign w_beat      = bus.in_valid & r_in_ready;
   assign w_sum_ext   = {1'b0, r_acc} + {1'b0, bus.in_data};
   assign w_cout      = w_sum_ext[WIDTH];
   // signed overflow: operands agree in sign, result does not
   assign w_add_ovf   = (r_acc[MSB] == bus.in_data[MSB]) &&
                        (w_sum_ext[MSB] != r_acc[MSB]);
   assign w_count_inc = (r_count == c_cnt_max) ? r_count : r_count + 1'b1;

`ifdef ADDER16_ACCUM_SAT_EN
   // clamp toward the sign both operands shared; carry still sees the raw add
   assign w_acc_next  = !w_add_ovf  ? w_sum_ext[MSB:0] :
                        r_acc[MSB]  ? c_sat_min : c_sat_max;
`else
   assign w_acc_next  = w_sum_ext[MSB:0];
`endif

   // packet FSM: accumulator, sticky flags, beat count and registered handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_beat) begin
                  r_acc   <= bus.in_data;
                  r_carry <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_count <= c_cnt_one;
                  if (bus.in_last) begin
                     r_state     <= S_HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (w_beat) begin
                  r_acc   <= w_acc_next;
                  r_carry <= r_carry | w_cout;
                  r_ovf   <= r_ovf | w_add_ovf;
                  r_count <= w_count_inc;
                  if (bus.in_last) begin
                     r_state     <= S_HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               // in_ready stays low on the return to IDLE edge, so the
               // earliest next beat lands one cycle later (the bubble)
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_sum      = r_acc;
   assign bus.out_sign     = r_acc[MSB];
   assign bus.out_zero     = (r_acc == '0);
   assign bus.out_parity   = ~^r_acc;
   assign bus.out_carry    = r_carry;
   assign bus.out_overflow = r_ovf;
   assign bus.out_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adder16_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder16_accum
// Description : Self-checking bench for adder16_accum. Expected results come
//               from an integer-arithmetic packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder16_accum;
   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [15:0] pkt[$];
   logic [15:0] e_sum;
   bit          e_carry;
   bit          e_ovf;
   int          e_cnt;

   always #5 clk = ~clk;

   adder16_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

   adder16_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   function automatic int to_s(logic [15:0] x);
      return x[15] ? int'(x) - 65536 : int'(x);
   endfunction

   // reference: sum the packet as plain integers, flag out-of-range results
   task automatic model();
      int unsigned a;
      int unsigned raw;
      int          ss;
      bit          ov;
      a = pkt[0]; e_carry = 0; e_ovf = 0; e_cnt = 1;
      for (int i = 1; i < pkt.size(); i++) begin
         raw = a + int'(pkt[i]);
         ss  = to_s(a[15:0]) + to_s(pkt[i]);
         ov  = (ss > 32767) || (ss < -32768);
         if (raw > 65535) e_carry = 1;
         if (ov) e_ovf = 1;
`ifdef ADDER16_ACCUM_SAT_EN
         if (ov) a = (ss > 0) ? 32'h7FFF : 32'h8000;
         else    a = raw & 32'hFFFF;
`else
         a = raw & 32'hFFFF;
`endif
         if (e_cnt < 255) e_cnt++;
      end
      e_sum = a[15:0];
   endtask

   task automatic send_beat(input logic [15:0] d, input bit last);
      int n;
      n = 0;
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) begin
         checks++; failures++;
         $display("FAIL beat_accept: in_ready=%b required 1 within 20 cycles", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   // send pkt, check the held result against the model, then drain it
   task automatic run_packet(input string name);
      model();
      for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
      checks++; if (bus.out_valid !== 1'b1) begin failures++;
         $display("FAIL %s latency: out_valid=%b required 1", name, bus.out_valid); end
      checks++; if (bus.out_sum !== e_sum) begin failures++;
         $display("FAIL %s sum: got %h required %h", name, bus.out_sum, e_sum); end
      checks++; if (bus.out_sign !== e_sum[15]) begin failures++;
         $display("FAIL %s sign: got %b required %b", name, bus.out_sign, e_sum[15]); end
      checks++; if (bus.out_zero !== (e_sum == 16'h0)) begin failures++;
         $display("FAIL %s zero: got %b required %b", name, bus.out_zero, e_sum == 16'h0); end
      checks++; if (bus.out_parity !== ($countones(e_sum) % 2 == 0)) begin failures++;
         $display("FAIL %s parity: got %b sum %h", name, bus.out_parity, e_sum); end
      checks++; if (bus.out_carry !== e_carry) begin failures++;
         $display("FAIL %s carry: got %b required %b", name, bus.out_carry, e_carry); end
      checks++; if (bus.out_overflow !== e_ovf) begin failures++;
         $display("FAIL %s overflow: got %b required %b", name, bus.out_overflow, e_ovf); end
      checks++; if (int'(bus.out_count) != e_cnt) begin failures++;
         $display("FAIL %s count: got %0d required %0d", name, bus.out_count, e_cnt); end
      bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++;
         $display("FAIL %s drain: out_valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
      #23 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_sum !== 16'h0 || bus.out_count !== 8'h0) begin failures++;
         $display("FAIL reset_data: sum=%h count=%0d required 0/0", bus.out_sum, bus.out_count); end
      checks++; if ({bus.out_sign, bus.out_zero, bus.out_carry, bus.out_parity, bus.out_overflow} !== 5'b01010) begin failures++;
         $display("FAIL reset_flags: SZCPO=%b required 01010",
                  {bus.out_sign, bus.out_zero, bus.out_carry, bus.out_parity, bus.out_overflow}); end
   endtask

   task automatic test_directed();
      pkt = '{16'h8FFF, 16'h8000};          run_packet("overflow");
      pkt = '{16'hFFFE, 16'h0002};          run_packet("wrap_zero");
      pkt = '{16'hAAAA, 16'h5555};          run_packet("all_ones");
      pkt = '{16'hFFFF, 16'h0001, 16'h0005}; run_packet("sticky_carry");
      pkt = '{16'h8001};                    run_packet("single_beat");
      pkt = '{16'h7FFF, 16'h0001, 16'hFFFF}; run_packet("pos_ovf");
   endtask

   task automatic test_reset_midpacket();
      send_beat(16'h1234, 0);
      send_beat(16'h1111, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_sum !== 16'h0 || bus.out_count !== 8'h0 || bus.out_valid !== 1'b0) begin failures++;
         $display("FAIL midpkt_async: sum=%h count=%0d valid=%b required 0/0/0", bus.out_sum, bus.out_count, bus.out_valid); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++;
         $display("FAIL midpkt_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
      pkt = '{16'h0001}; run_packet("after_reset");
      // reset while a result is held
      send_beat(16'h5555, 1);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'h0) begin failures++;
         $display("FAIL hold_async: out_valid=%b sum=%h required 0/0000", bus.out_valid, bus.out_sum); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      pkt = '{16'h0100, 16'h0200, 16'h0300};
      model();
      for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
      // next packet already offered while the result is stalled
      bus.in_valid = 1'b1; bus.in_data = 16'h7FFF; bus.in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                       bus.out_sum !== e_sum || int'(bus.out_count) != e_cnt) begin failures++;
            $display("FAIL stall_c%0d: in_ready=%b valid=%b sum=%h count=%0d required 0/1/%h/%0d",
                     c, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, e_sum, e_cnt); end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++;
         $display("FAIL bubble: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h7FFF || bus.out_count !== 8'd1) begin failures++;
         $display("FAIL after_stall: valid=%b sum=%h count=%0d required 1/7fff/1", bus.out_valid, bus.out_sum, bus.out_count); end
      bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
   endtask

   task automatic test_ignored();
      // in_last without in_valid, out_ready outside HOLD
      bus.in_last = 1'b1; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++;
         $display("FAIL ignored_last: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready); end
      bus.in_last = 1'b0; bus.out_ready = 1'b0;
      pkt = '{16'h0F0F, 16'h00F0}; run_packet("after_ignored");
   endtask

   task automatic test_saturation();
      pkt.delete();
      for (int i = 0; i < 300; i++) pkt.push_back(16'($urandom()));
      run_packet("count_sat");
   endtask

   task automatic test_random();
      int n;
      int k;
      for (int p = 0; p < 25; p++) begin
         pkt.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 4);
            case (k)
               0: pkt.push_back(16'h7FFF);
               1: pkt.push_back(16'h8000);
               2: pkt.push_back(16'hFFFF);
               default: pkt.push_back(16'($urandom()));
            endcase
         end
         run_packet("random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_midpacket();
      test_back_to_back();
      test_ignored();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // hard stop in case a handshake never completes
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/adder16_accum.md
Name: adder16_accum

Overview:
- Streaming 16-bit accumulator that sits directly downstream of the adder16 datapath.
- Sums a packet of operands, delimited by in_last, into a running 16-bit total.
- Reports the total with the same flag set as adder16: Sign, Zero, Carry, Parity, Overflow.
- Carry and Overflow are sticky across the packet.
- Valid/ready on both sides; one result per packet is presented to the status/writeback logic.

Parameters:
- WIDTH, 16: operand and accumulator width; flags are defined on bit WIDTH-1.
- CNT_W, 8: width of the beat counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: accumulator can accept a beat.
- in_data, input, WIDTH: operand, two's complement.
- in_last, input, 1: final beat of the packet; qualified by in_valid.
- out_valid, output, 1: result held and valid.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, WIDTH: accumulated sum.
- out_sign, output, 1: out_sum[WIDTH-1].
- out_zero, output, 1: 1 when out_sum==0.
- out_carry, output, 1: sticky OR of the unsigned carry-out over every add in the packet.
- out_parity, output, 1: 1 when out_sum contains an even number of ones (XNOR reduction).
- out_overflow, output, 1: sticky OR of signed overflow over every add in the packet.
- out_count, output, CNT_W: beats accepted in the packet, saturating.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is asynchronous, active-low (rst_n); all state clears immediately on assertion.
- Reset values:
  - State IDLE; accumulator, sticky flags and count all 0.
  - out_valid=0; out_sum=0, so out_zero=1, out_parity=1, other flags 0.
  - in_ready=1 once rst_n is high.
- Handshakes:
  - A beat transfers when in_valid & in_ready at a clk edge; a result transfers when out_valid & out_ready.
  - in_ready is a function of registered state only, with no combinational path from out_ready.
- FSM:
  - IDLE (in_ready=1, out_valid=0):
    - On a transfer: acc<=in_data, carry_st<=0, ovf_st<=0, count<=1.
    - If in_last, go to HOLD; otherwise go to ACC.
  - ACC (in_ready=1, out_valid=0):
    - On a transfer: acc<=acc+in_data (WIDTH-bit wrap), carry_st|=cout, ovf_st|=(acc[MSB]==in_data[MSB] && sum[MSB]!=acc[MSB]), count<=count+1 (saturating).
    - If in_last, go to HOLD.
    - With no transfer, all state holds.
  - HOLD (in_ready=0, out_valid=1):
    - All out_* are stable and unchanged until the transfer.
    - On out_ready, go to IDLE.
    - One bubble cycle is mandatory before the next packet.
- Derived flags: out_sign, out_zero and out_parity are decoded combinationally from the registered acc.
- Latency: out_valid rises on the clk edge after the in_last beat is accepted, i.e. 1 cycle.
- Boundary conditions:
  - Single-beat packet (in_last on the first beat): out_sum=in_data, carry=0, overflow=0, count=1.
  - Count saturation: count stops at 2^CNT_W-1 while accumulation continues.
  - in_last asserted without in_valid is ignored.
  - out_ready high outside HOLD is ignored.
  - rst_n low mid-packet or in HOLD discards the partial sum; out_valid drops immediately.

Optional Feature:
- Macro: ADDER16_ACCUM_SAT_EN.
- Defined:
  - On a signed-overflow add, acc clamps to 0x7FFF (both operands positive) or 0x8000 (both negative).
  - Later adds continue from the clamped value.
  - ovf_st is still set.
  - carry_st reflects the raw unclamped carry-out.
- Undefined: two's-complement wrap as described above; no clamp logic is synthesised.

Test Plan:
- Reset mid-packet:
  - Stimulus: after beats 0x1234, 0x1111 (no last), pulse rst_n low asynchronously.
  - Response: out_valid=0 and in_ready=1 immediately after release; next packet 0x0001+last gives out_sum=0x0001, count=1.
- Signed and unsigned overflow:
  - Stimulus: packet 0x8FFF, 0x8000+last.
  - Response: out_sum=0x0FFF, sign=0, zero=0, carry=1, overflow=1, parity=1 (12 ones), count=2.
  - With ADDER16_ACCUM_SAT_EN: out_sum=0x8000, overflow=1.
- Wrap to zero:
  - Stimulus: packet 0xFFFE, 0x0002+last.
  - Response: out_sum=0x0000, zero=1, carry=1, overflow=0, parity=1, sign=0.
- All-ones result:
  - Stimulus: packet 0xAAAA, 0x5555+last.
  - Response: out_sum=0xFFFF, sign=1, zero=0, carry=0, overflow=0, parity=1.
- Sticky carry:
  - Stimulus: packet 0xFFFF, 0x0001, 0x0005+last.
  - Response: out_sum=0x0005, carry=1 (sticky from beat 2), overflow=0, count=3.
- Backpressure on result:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD while in_valid=1.
  - Response: in_ready=0 and out_* constant throughout; after out_ready=1, one IDLE cycle with in_ready=1.
  - Response: a single-beat packet 0x7FFF+last then gives out_sum=0x7FFF, count=1.
